// File: rtl/multiplicador_reg.sv
// Two-stage pipelined signed multiplier: registered operands, then registered
// full-precision product (Q1+Q2 bits, exact).
module multiplicador_reg #(
    parameter int Q1 = 14,
    parameter int Q2 = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic signed [Q1-1:0] x1,
    input  logic signed [Q2-1:0] x2,
    output logic signed [Q1+Q2-1:0] y
);
    localparam int QW = Q1 + Q2;

    logic signed [Q1-1:0] r_x1;
    logic signed [Q2-1:0] r_x2;
    logic signed [QW-1:0] r_y;
    logic signed [QW-1:0] w_x1_ext;
    logic signed [QW-1:0] w_x2_ext;
    logic signed [QW-1:0] w_prod;

    // Widening both operands to the product width keeps the multiply exact;
    // the most negative corner product still fits in QW signed bits.
    assign w_x1_ext = {{Q2{r_x1[Q1-1]}}, r_x1};
    assign w_x2_ext = {{Q1{r_x2[Q2-1]}}, r_x2};
    assign w_prod   = w_x1_ext * w_x2_ext;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_x1 <= '0;
            r_x2 <= '0;
            r_y  <= '0;
        end else begin
            r_x1 <= x1;
            r_x2 <= x2;
            r_y  <= w_prod;
        end
    end

    assign y = r_y;
endmodule

// File: tb/tb_multiplicador_reg.sv
// Self-checking bench for multiplicador_reg: directed corner cases plus
// randomized back-to-back operands against a per-edge arithmetic reference.
module tb_multiplicador_reg;
    localparam int Q1 = 14;
    localparam int Q2 = 16;
    localparam int QW = Q1 + Q2;

    logic                 clk;
    logic                 reset_n;
    logic signed [Q1-1:0] x1;
    logic signed [Q2-1:0] x2;
    logic signed [QW-1:0] y;

    int errs;
    int checks;

    // Reference state: operands and reset level seen at the previous edge.
    int   prev_a;
    int   prev_b;
    logic prev_r;

    multiplicador_reg #(.Q1(Q1), .Q2(Q2)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .x1     (x1),
        .x2     (x2),
        .y      (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one operand pair for one edge, then check y right after that edge.
    // Rule: y after edge k is x1*x2 sampled at edge k-1, unless reset was low
    // at edge k or at edge k-1, in which case y is 0.
    task automatic tick(input int a, input int b, input logic r, input string name);
        longint               p;
        logic signed [QW-1:0] exp_y;
        x1      = Q1'(a);
        x2      = Q2'(b);
        reset_n = r;
        @(posedge clk);
        #1;
        if (!r || !prev_r) p = 0;
        else               p = longint'(prev_a) * longint'(prev_b);
        exp_y = QW'(p);
        checks++;
        if (y !== exp_y) begin
            errs++;
            $display("FAIL %s: y=%0d (0x%h) expected %0d (0x%h)", name, y, y, exp_y, exp_y);
        end
        prev_a = int'($signed(x1));
        prev_b = int'($signed(x2));
        prev_r = r;
    endtask

    task automatic pair(input int a, input int b, input string name);
        tick(a, b, 1'b1, {name, "_lat1"});
        tick(a, b, 1'b1, name);
        tick(a, b, 1'b1, {name, "_hold"});
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) tick(100, 200, 1'b0, "reset_hold");
        tick(100, 200, 1'b1, "reset_release_lat1");
        tick(100, 200, 1'b1, "reset_release_20000");
    endtask

    task automatic test_basic;
        tick(32, 16, 1'b1, "basic_512_lat");
        tick(32, 16, 1'b1, "basic_512");
        tick(64, 128, 1'b1, "basic_hold_512");
        tick(64, 128, 1'b1, "basic_8192");
        for (int i = 0; i < 3; i++) tick(64, 128, 1'b1, "basic_steady_8192");
    endtask

    task automatic test_signs;
        pair(-1, -1, "sign_m1_m1");
        pair(-5, 7, "sign_m5_7");
        pair(8191, -32768, "sign_max_min");
    endtask

    task automatic test_extremes;
        pair(-8192, -32768, "ext_min_min");
        pair(-8192, 32767, "ext_min_max");
        pair(8191, 32767, "ext_max_max");
        pair(0, -32768, "zero_x1");
        pair(-8192, 0, "zero_x2");
    endtask

    task automatic test_back_to_back;
        logic [Q1-1:0] ra;
        logic [Q2-1:0] rb;
        int            a;
        int            b;
        for (int i = 0; i < 1000; i++) begin
            ra = Q1'($urandom);
            rb = Q2'($urandom);
            a  = int'($signed(ra));
            b  = int'($signed(rb));
            if ($urandom_range(0, 15) == 0) a = 0;
            if ($urandom_range(0, 15) == 0) b = 0;
            tick(a, b, 1'b1, "b2b_random");
        end
    endtask

    task automatic test_reset_midstream;
        tick(1234, -4321, 1'b1, "mid_pre0");
        tick(-777, 555, 1'b1, "mid_pre1");
        tick(999, 999, 1'b0, "mid_reset_zero");
        tick(3, 5, 1'b1, "mid_release_zero");
        tick(11, -13, 1'b1, "mid_first_15");
        tick(11, -13, 1'b1, "mid_second_m143");
        tick(-4096, 2, 1'b1, "mid_hold");
        tick(-4096, 2, 1'b1, "mid_after");
    endtask

    initial begin
        errs    = 0;
        checks  = 0;
        prev_a  = 0;
        prev_b  = 0;
        prev_r  = 1'b0;
        reset_n = 1'b0;
        x1      = '0;
        x2      = '0;
        test_reset;
        test_basic;
        test_signs;
        test_extremes;
        test_back_to_back;
        test_reset_midstream;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/multiplicador_reg.md
Name:
multiplicador_reg

Overview:
- Pipelined, full-precision signed multiplier.
- Computes the product of a Q1-bit sample (e.g. 14-bit ADC data) and a Q2-bit coefficient (e.g. 16-bit reference or sine table value).
- Used in the lock-in / coherent-average datapath wherever a sample is multiplied by a reference.
- Output is registered, with a fixed latency and no handshake.

Parameters:
- Q1, 14, width of operand x1 (two's complement).
- Q2, 16, width of operand x2 (two's complement).
- Product width is derived, not a parameter: Q1+Q2.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- reset_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
- x1  input  Q1  multiplicand, signed two's complement.
- x2  input  Q2  multiplier, signed two's complement.
- y  output  Q1+Q2  product x1*x2, signed two's complement, registered.

Behaviour:
- One clock domain (clk) and synchronous active-low reset_n; no other clocks and no asynchronous reset.
- Reset:
  - When reset_n=0 at a rising edge, all pipeline registers clear to 0.
  - y=0 from that edge on, for as long as reset_n stays low.
- Pipeline has 2 register stages:
  - Stage 1 captures x1 and x2 into input registers on every edge.
  - Stage 2 registers the product of the stage-1 operands into y.
- Latency: operands present at rising edge N appear on y after rising edge N+1 (2-edge latency).
- Throughput is one new operand pair per cycle; there is no stall or enable.
- Arithmetic:
  - Both operands are sign-extended to Q1+Q2 bits before multiplying.
  - The result is exact and full-width: no truncation, rounding or saturation.
  - Overflow is impossible. The extreme case (-2^(Q1-1))*(-2^(Q2-1)) = 2^(Q1+Q2-2) still fits in Q1+Q2 signed bits.
- Zero operand: if either operand is 0, y=0 after the latency, for any value of the other operand.
- Reset mid-operation:
  - Products in flight are discarded; no stale product appears after reset releases.
  - After reset_n returns high, the first valid y is produced 2 edges after the first sampled operand pair.
  - Until then y holds 0.
- Steady inputs: y holds the same product indefinitely.
- Implementation freedom:
  - The multiply may use an inferred signed multiply or vendor DSP blocks.
  - It may also be split across the two stages as a partial-product/adder tree.
  - Whatever the structure, the 2-cycle latency and bit-exact results are mandatory.
- No X propagation: y is never X after the first edge with reset_n=0.

Test Plan:
- Reset: hold reset_n=0 for 3 edges with x1=100, x2=200 -> y=0 throughout. Release reset -> y=20000 two edges later.
- Basic: x1=32, x2=16 -> y=512 after 2 edges. Switch to x1=64, x2=128 -> y=8192 exactly 2 edges after the change, and y=512 held until then.
- Signs:
  - x1=-1, x2=-1 -> y=1.
  - x1=-5, x2=7 -> y=-35 (30-bit 0x3FFFFFDD).
  - x1=8191, x2=-32768 -> y=-268402688.
- Extremes:
  - x1=-8192, x2=-32768 -> y=268435456 (0x10000000).
  - x1=-8192, x2=32767 -> y=-268427264.
  - x1=8191, x2=32767 -> y=268394497.
- Back-to-back: change operands every cycle with random signed values for 1000 cycles -> each y equals the reference product of the pair applied 2 edges earlier. Also include zero operands -> y=0.
- Reset mid-stream:
  - Assert reset_n=0 for 1 edge while products are in flight -> y=0 on the next edge.
  - Neither pre-reset product appears after release.
